// File: rtl/example_vector_sequencer.sv
// example_vector_sequencer
//
// Clocked stimulus controller for delay characterisation of the `example`
// datapath. Operand pairs are queued in a FIFO and applied to the datapath one
// at a time. Each pair is held for a programmable settle time before `c` is
// sampled. Every result is returned with its operands and a cycle timestamp
// over a valid/ready port.
//
// Ports
//   clk, rst_n          sole clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   vector push handshake; in_ready = FIFO not full
//   in_a, in_b          operands to queue
//   settle_cycles       settle delay N, sampled at each pop (capture at pop+N+1)
//   run                 level; permits popping new vectors
//   flush               synchronous abort: empties FIFO, drops in-flight vector
//   dut_a, dut_b        registered drive to example.a / example.b
//   dut_c               from example.c
//   res_valid/res_ready result handshake
//   res_a, res_b, res_c operands and captured result
//   res_time            free-running cycle counter value at capture
//   fifo_count          entries queued
//   busy                sequencer not idle

module example_vector_sequencer #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned RES_W   = 8,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned DELAY_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_a,
   input  logic [DATA_W-1:0]        in_b,
   input  logic [DELAY_W-1:0]       settle_cycles,
   input  logic                     run,
   input  logic                     flush,
   output logic [DATA_W-1:0]        dut_a,
   output logic [DATA_W-1:0]        dut_b,
   input  logic [RES_W-1:0]         dut_c,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [DATA_W-1:0]        res_a,
   output logic [DATA_W-1:0]        res_b,
   output logic [RES_W-1:0]         res_c,
   output logic [31:0]              res_time,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StResult
   } state_e;

   state_e               state_q, state_d;
   logic [DELAY_W-1:0]   settle_q, settle_d;
   logic [31:0]          cycle_q;
   logic [CNT_W-1:0]     count_q;
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [2*DATA_W-1:0]  mem_q [DEPTH];

   logic push, pop, capture, res_clear, fifo_nonempty;

   assign in_ready      = (count_q != CNT_W'(DEPTH));
   assign fifo_nonempty = (count_q != '0);
   // A flush in the same cycle discards any push.
   assign push          = in_valid && in_ready && !flush;
   assign fifo_count    = count_q;
   assign busy          = (state_q != StIdle);

   // ------------------------------------------------------------------------
   // Sequencer FSM: next state and control strobes
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      pop       = 1'b0;
      capture   = 1'b0;
      res_clear = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (run && fifo_nonempty) begin
               pop      = 1'b1;
               settle_d = settle_cycles;
               state_d  = StSettle;
            end
         end
         StSettle: begin
            if (settle_q == '0) begin
               capture = 1'b1;
               state_d = StResult;
            end else begin
               settle_d = settle_q - DELAY_W'(1);
            end
         end
         StResult: begin
            if (res_ready) begin
               res_clear = 1'b1;
               // Back-to-back: pop the next vector on the accepting edge.
               if (run && fifo_nonempty) begin
                  pop      = 1'b1;
                  settle_d = settle_cycles;
                  state_d  = StSettle;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (flush) begin
         state_d = StIdle;
         pop     = 1'b0;
         capture = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // State, FIFO control, cycle counter and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         settle_q  <= '0;
         cycle_q   <= '0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         dut_a     <= '0;
         dut_b     <= '0;
         res_valid <= 1'b0;
         res_a     <= '0;
         res_b     <= '0;
         res_c     <= '0;
         res_time  <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         cycle_q  <= cycle_q + 32'd1;

         if (flush) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
         end

         // dut_* hold their last applied operands; only a pop or reset changes them.
         if (pop) begin
            {dut_a, dut_b} <= mem_q[rd_ptr_q];
         end

         if (flush) begin
            res_valid <= 1'b0;
         end else if (capture) begin
            res_valid <= 1'b1;
         end else if (res_clear) begin
            res_valid <= 1'b0;
         end

         if (capture) begin
            res_a    <= dut_a;
            res_b    <= dut_b;
            res_c    <= dut_c;
            res_time <= cycle_q;
         end
      end
   end

   // FIFO storage needs no reset; count_q guards every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_a, in_b};
      end
   end

endmodule

// File: tb/tb_example_vector_sequencer.sv
// Directed testbench for example_vector_sequencer. The `example` datapath is
// modelled as c = a + b driven from the sequencer's dut_a/dut_b.

module tb_example_vector_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a, in_b;
   logic [7:0]  settle_cycles;
   logic        run;
   logic        flush;
   logic [7:0]  dut_a, dut_b, dut_c;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_a, res_b, res_c;
   logic [31:0] res_time;
   logic [3:0]  fifo_count;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign dut_c = dut_a + dut_b;

   example_vector_sequencer #(
      .DATA_W  (8),
      .RES_W   (8),
      .DEPTH   (8),
      .DELAY_W (8)
   ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_a          (in_a),
      .in_b          (in_b),
      .settle_cycles (settle_cycles),
      .run           (run),
      .flush         (flush),
      .dut_a         (dut_a),
      .dut_b         (dut_b),
      .dut_c         (dut_c),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_a         (res_a),
      .res_b         (res_b),
      .res_c         (res_c),
      .res_time      (res_time),
      .fifo_count    (fifo_count),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled at the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin : stim
      logic [7:0]  exp_c [5];
      logic [31:0] prev_time;
      int          idx;

      exp_c[0] = 8'd3; exp_c[1] = 8'd2; exp_c[2] = 8'd5; exp_c[3] = 8'd6; exp_c[4] = 8'd8;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      settle_cycles = '0; run = 1'b0; flush = 1'b0; res_ready = 1'b0;
      tick(); tick();

      // ---- Reset state ----
      check("rst_dut_a", dut_a, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_c", res_c, 0);
      check("rst_res_time", res_time, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      tick();

      // ---- Single vector, N=3 ----
      settle_cycles = 8'd3;
      push(8'd1, 8'd2);
      check("single_count", fifo_count, 1);
      run = 1'b1;
      tick();                                   // pop edge E0
      check("single_dut_a", dut_a, 1);
      check("single_dut_b", dut_b, 2);
      check("single_busy", busy, 1);
      check("single_count_pop", fifo_count, 0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("single_early_valid", res_valid, 0);
      end
      tick();                                   // E0+4
      check("single_valid", res_valid, 1);
      check("single_res_c", res_c, 3);
      check("single_res_a", res_a, 1);
      check("single_res_b", res_b, 2);
      run = 1'b0;
      res_ready = 1'b1;
      tick();
      check("single_valid_clr", res_valid, 0);
      check("single_idle", busy, 0);
      res_ready = 1'b0;

      // ---- Stream, N=0, res_ready high ----
      settle_cycles = 8'd0;
      push(8'd1, 8'd2); push(8'd1, 8'd1); push(8'd3, 8'd2); push(8'd4, 8'd2); push(8'd5, 8'd3);
      check("stream_count", fifo_count, 5);
      res_ready = 1'b1;
      run = 1'b1;
      idx = 0;
      prev_time = '0;
      for (int cyc = 0; cyc < 60 && idx < 5; cyc++) begin
         tick();
         if (res_valid) begin
            check("stream_res_c", res_c, exp_c[idx]);
            if (idx > 0) check("stream_time_step", res_time - prev_time, 2);
            prev_time = res_time;
            idx++;
         end
      end
      check("stream_num_results", idx, 5);
      run = 1'b0;
      tick();
      check("stream_idle", busy, 0);
      check("stream_empty", fifo_count, 0);
      res_ready = 1'b0;

      // ---- Full / backpressure ----
      settle_cycles = 8'd1;
      for (int i = 0; i < 8; i++) begin
         push(8'(i + 1), 8'd10);
         if (i == 6) check("full_ready_at7", in_ready, 1);
      end
      check("full_ready_at8", in_ready, 0);
      check("full_count8", fifo_count, 8);
      push(8'd99, 8'd99);
      check("full_count_after9", fifo_count, 8);
      run = 1'b1;
      tick();                                   // pop
      check("full_count_pop", fifo_count, 7);
      tick(); tick();                           // capture at E0+2
      check("full_valid", res_valid, 1);
      check("full_res_c", res_c, 11);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("full_hold_c", res_c, 11);
         check("full_hold_count", fifo_count, 7);
      end
      run = 1'b0;
      res_ready = 1'b1;
      tick();
      check("full_released", res_valid, 0);
      check("full_count_end", fifo_count, 7);
      res_ready = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("full_flush_count", fifo_count, 0);

      // ---- Run drop during SETTLE ----
      settle_cycles = 8'd2;
      push(8'd2, 8'd3); push(8'd4, 8'd4); push(8'd6, 8'd1);
      run = 1'b1;
      tick();                                   // pop vector 1
      run = 1'b0;
      tick(); tick(); tick();                   // capture at E0+3
      check("rundrop_valid", res_valid, 1);
      check("rundrop_res_c", res_c, 5);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("rundrop_idle", busy, 0);
      check("rundrop_count", fifo_count, 2);
      tick();
      check("rundrop_no_pop", fifo_count, 2);

      // ---- Flush in SETTLE with 3 queued ----
      push(8'd7, 8'd7); push(8'd8, 8'd8);
      run = 1'b1;
      tick();                                   // pops (4,4)
      run = 1'b0;
      check("flush_pre_count", fifo_count, 3);
      check("flush_pre_busy", busy, 1);
      flush = 1'b1;
      in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_count", fifo_count, 0);
      check("flush_valid", res_valid, 0);
      check("flush_idle", busy, 0);
      check("flush_dut_a_kept", dut_a, 4);
      tick();
      check("flush_push_dropped", fifo_count, 0);

      // ---- Asynchronous reset mid-RESULT ----
      settle_cycles = 8'd0;
      push(8'd5, 8'd5);
      run = 1'b1;
      tick(); tick();
      check("arst_pre_valid", res_valid, 1);
      check("arst_pre_res_c", res_c, 10);
      #1 rst_n = 1'b0;
      #1;
      check("arst_dut_a", dut_a, 0);
      check("arst_dut_b", dut_b, 0);
      check("arst_res_valid", res_valid, 0);
      check("arst_res_a", res_a, 0);
      check("arst_res_b", res_b, 0);
      check("arst_res_c", res_c, 0);
      check("arst_res_time", res_time, 0);
      check("arst_fifo_count", fifo_count, 0);
      check("arst_busy", busy, 0);
      run = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
